// File: rtl/simplez_runctl.sv
// rtl/simplez_runctl.sv - run controller for the simplez CPU: reset pulse, clock enable, cycle budget.
// Optional leds_in/leds_snap capture on DONE entry with `define SIMPLEZ_RUNCTL_SNAPSHOT_EN.
module simplez_runctl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 100,
  parameter int LED_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             cpu_stop,
  output logic             cpu_rstn,
  output logic             cpu_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
`ifdef SIMPLEZ_RUNCTL_SNAPSHOT_EN
  ,
  input  logic [LED_W-1:0] leds_in,
  output logic [LED_W-1:0] leds_snap
`endif
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam logic [RCW-1:0]   RST_LOAD  = RCW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);
  localparam logic             BUDGET_EN = (MAX_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [RCW-1:0]   rst_cnt, rst_cnt_n;
  logic             step_q;
  logic             rstn_n, en_n, running_n, done_n, timeout_n;
  logic [CNT_W-1:0] cnt_n, cnt_adv;
  logic             step_edge;

  assign step_edge = step_req & ~step_q;
  // Saturating advance of the count for the cycle currently enabled.
  assign cnt_adv = (cpu_en && (cycle_count != {CNT_W{1'b1}})) ? cycle_count + 1'b1 : cycle_count;

  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    rstn_n    = cpu_rstn;
    en_n      = 1'b0;
    done_n    = done;
    timeout_n = timeout;
    cnt_n     = cycle_count;
    case (state)
      IDLE: begin
        rstn_n = 1'b0;
        if (start) begin
          state_n   = RESET;
          rst_cnt_n = RST_LOAD;
          cnt_n     = '0;
          done_n    = 1'b0;
          timeout_n = 1'b0;
        end
      end
      RESET: begin
        rstn_n = 1'b0;
        if (rst_cnt == '0) begin
          state_n = RUN;
          rstn_n  = 1'b1;
          en_n    = step_mode ? step_edge : 1'b1;
        end else begin
          rst_cnt_n = rst_cnt - 1'b1;
        end
      end
      RUN: begin
        cnt_n = cnt_adv;
        if (cpu_stop) begin
          state_n   = DONE;
          done_n    = 1'b1;
          timeout_n = 1'b0;
        end else if (BUDGET_EN && (cnt_adv == MAX_C)) begin
          state_n   = DONE;
          done_n    = 1'b1;
          timeout_n = 1'b1;
        end else begin
          en_n = step_mode ? step_edge : 1'b1;
        end
      end
      DONE: begin
        // CPU reset stays released so its final state can be inspected.
        if (start) begin
          state_n   = RESET;
          rst_cnt_n = RST_LOAD;
          rstn_n    = 1'b0;
          cnt_n     = '0;
          done_n    = 1'b0;
          timeout_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        rstn_n  = 1'b0;
      end
    endcase
    running_n = (state_n == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      step_q      <= 1'b0;
      cpu_rstn    <= 1'b0;
      cpu_en      <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_n;
      rst_cnt     <= rst_cnt_n;
      step_q      <= step_req;
      cpu_rstn    <= rstn_n;
      cpu_en      <= en_n;
      running     <= running_n;
      done        <= done_n;
      timeout     <= timeout_n;
      cycle_count <= cnt_n;
    end
  end

`ifdef SIMPLEZ_RUNCTL_SNAPSHOT_EN
  logic enter_reset, enter_done;
  assign enter_reset = (state_n == RESET) && (state != RESET);
  assign enter_done  = (state_n == DONE) && (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_snap <= '0;
    end else if (enter_reset) begin
      leds_snap <= '0;
    end else if (enter_done) begin
      leds_snap <= leds_in;
    end
  end
`endif

endmodule
